// File: rtl/mod_counter.sv
// Parametrised modulo-N up/down counter with parallel load, terminal count and wrap pulse.
// Latency: Q and wrap update one clk edge after the inputs are sampled; tc is combinational.
// Backpressure: none; EC=1 holds the count. Build option CNT_SATURATE_EN clamps at the bounds instead of wrapping.
module mod_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = MODULUS - 1
) (
    input  logic             clk,
    input  logic             r,
    input  logic             EC,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VAL);

    logic             at_top;
    logic             at_bot;
    logic             d_in_range;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;

    assign at_top     = (Q == MAXV);
    assign at_bot     = (Q == '0);
    assign d_in_range = (32'(D) < 32'(MODULUS));
    assign tc         = ~EC & ((up & at_top) | (~up & at_bot));

    always_comb begin
        q_nxt    = Q;
        wrap_nxt = 1'b0;
        if (ld) begin
            q_nxt = d_in_range ? D : MAXV;
        end else if (!EC) begin
            if (up) begin
                if (at_top) begin
`ifdef CNT_SATURATE_EN
                    q_nxt = MAXV;
`else
                    q_nxt    = '0;
                    wrap_nxt = 1'b1;
`endif
                end else begin
                    q_nxt = Q + WIDTH'(1);
                end
            end else begin
                if (at_bot) begin
`ifdef CNT_SATURATE_EN
                    q_nxt = '0;
`else
                    q_nxt    = MAXV;
                    wrap_nxt = 1'b1;
`endif
                end else begin
                    q_nxt = Q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!r) begin
            Q    <= RSTV;
            wrap <= 1'b0;
        end else begin
            Q    <= q_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: a MODULUS=10 and a MODULUS=16 instance share stimulus and are
// checked every cycle against an arithmetic model, plus hand-computed directed expectations.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       r   = 1'b0;
    logic       EC  = 1'b1;
    logic       up  = 1'b1;
    logic       ld  = 1'b0;
    logic [3:0] D   = '0;
    logic [3:0] q10, q16;
    logic       tc10, tc16, wr10, wr16;

    int checks   = 0;
    int failures = 0;

    int m_q10 = 0, m_q16 = 0;
    bit m_w10 = 0, m_w16 = 0;
    bit m_valid = 0;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(9)) dut (
        .clk(clk), .r(r), .EC(EC), .up(up), .ld(ld), .D(D),
        .Q(q10), .tc(tc10), .wrap(wr10)
    );

    mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk(clk), .r(r), .EC(EC), .up(up), .ld(ld), .D(D),
        .Q(q16), .tc(tc16), .wrap(wr16)
    );

    function automatic void model_step(input int modulus, input int rval, input int q,
                                       output int nq, output bit nw);
        int d;
        d  = int'(D);
        nq = q;
        nw = 0;
        if (!r) begin
            nq = rval;
        end else if (ld) begin
            nq = (d < modulus) ? d : modulus - 1;
        end else if (!EC) begin
`ifdef CNT_SATURATE_EN
            if (up) nq = (q + 1 > modulus - 1) ? modulus - 1 : q + 1;
            else    nq = (q - 1 < 0) ? 0 : q - 1;
`else
            if (up) begin
                nq = (q + 1) % modulus;
                nw = (q + 1 >= modulus);
            end else begin
                nq = (q + modulus - 1) % modulus;
                nw = (q - 1 < 0);
            end
`endif
        end
    endfunction

    function automatic bit model_tc(input int modulus, input int q);
        return !EC && ((up && q == modulus - 1) || (!up && q == 0));
    endfunction

    always @(posedge clk) begin
        int nq;
        bit nw;
        model_step(10, 9, m_q10, nq, nw);
        m_q10 = nq; m_w10 = nw;
        model_step(16, 15, m_q16, nq, nw);
        m_q16 = nq; m_w16 = nw;
        if (!r) m_valid = 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model q10",  32'(q10),  32'(m_q10));
            chk("model w10",  32'(wr10), 32'(m_w10));
            chk("model tc10", 32'(tc10), 32'(model_tc(10, m_q10)));
            chk("model q16",  32'(q16),  32'(m_q16));
            chk("model w16",  32'(wr16), 32'(m_w16));
            chk("model tc16", 32'(tc16), 32'(model_tc(16, m_q16)));
        end
    end

    task automatic set_in(input bit rr, input bit l, input bit ec, input bit u, input int d);
        r = rr; ld = l; EC = ec; up = u; D = 4'(d);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply(input bit rr, input bit l, input bit ec, input bit u, input int d);
        set_in(rr, l, ec, u, d);
        tick();
    endtask

    initial begin
        // reset beats load and count
        apply(0, 1, 0, 1, 3);
        apply(0, 1, 0, 1, 3);
        chk("rst q10", 32'(q10), 9);
        chk("rst w10", 32'(wr10), 0);
        chk("rst q16", 32'(q16), 15);
        apply(1, 0, 0, 1, 0);
`ifdef CNT_SATURATE_EN
        chk("resume q10", 32'(q10), 9);
        chk("resume w10", 32'(wr10), 0);
`else
        chk("resume q10", 32'(q10), 0);
        chk("resume w10", 32'(wr10), 1);
`endif

        // full up cycle from 0
        apply(1, 1, 1, 1, 0);
        chk("load0 q10", 32'(q10), 0);
        set_in(1, 0, 0, 1, 0);
        #1 chk("tc at 0 up", 32'(tc10), 0);
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("up seq q10", 32'(q10), 32'(i));
            chk("up seq w10", 32'(wr10), 0);
        end
        chk("tc at 9 up", 32'(tc10), 1);
        tick();
`ifdef CNT_SATURATE_EN
        chk("up wrap q10", 32'(q10), 9);
        chk("up wrap w10", 32'(wr10), 0);
`else
        chk("up wrap q10", 32'(q10), 0);
        chk("up wrap w10", 32'(wr10), 1);
`endif
        apply(1, 0, 1, 1, 0);
        chk("wrap pulse ends", 32'(wr10), 0);

        // down from 0
        apply(1, 1, 1, 1, 0);
        set_in(1, 0, 0, 0, 0);
        #1 chk("tc at 0 down", 32'(tc10), 1);
        tick();
`ifdef CNT_SATURATE_EN
        chk("down wrap q10", 32'(q10), 0);
        chk("down wrap w10", 32'(wr10), 0);
`else
        chk("down wrap q10", 32'(q10), 9);
        chk("down wrap w10", 32'(wr10), 1);
`endif

        // hold and clamp
        apply(1, 1, 0, 0, 4);
        for (int i = 0; i < 5; i++) apply(1, 0, 1, 1, 0);
        chk("hold q10", 32'(q10), 4);
        chk("hold tc10", 32'(tc10), 0);
        apply(1, 1, 1, 1, 12);
        chk("clamp q10", 32'(q10), 9);
        chk("noclamp q16", 32'(q16), 12);

        // load beats terminal count, then direction flip
        apply(1, 1, 0, 1, 2);
        chk("ld vs tc q10", 32'(q10), 2);
        chk("ld vs tc w10", 32'(wr10), 0);
        apply(1, 0, 0, 0, 0);
        chk("flip down q10", 32'(q10), 1);

        // upper bound on both moduli
        apply(1, 1, 1, 1, 15);
        chk("load15 q10", 32'(q10), 9);
        chk("load15 q16", 32'(q16), 15);
        set_in(1, 0, 0, 1, 0);
        #1 chk("tc16 at 15", 32'(tc16), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
`ifdef CNT_SATURATE_EN
            chk("sat q10", 32'(q10), 9);
            chk("sat w10", 32'(wr10), 0);
            chk("sat tc10", 32'(tc10), 1);
            chk("sat q16", 32'(q16), 15);
`else
            chk("bin q16", 32'(q16), 32'(i));
            chk("bin w16", 32'(wr16), (i == 0) ? 1 : 0);
`endif
        end

        // mixed directed-random traffic checked by the model
        for (int i = 0; i < 60; i++) begin
            apply(($urandom_range(0, 19) != 0), ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15));
        end

        @(posedge clk);
        #6;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
